// File: rtl/bubble_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bubble_fifo_pkg
// Shared constants, FSM state type and the header byte helper for the bubble
// FIFO UART transmitter.
// -----------------------------------------------------------------------------
package bubble_fifo_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TYPE_BOOT = 8'h42;
    localparam logic [7:0] TYPE_USER = 8'h55;

    localparam int BUF_DEPTH = 8192;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        SEND,
        CHK,
        DONE
    } state_t;

    // Header bytes in transmit order: sync, type, page high nibble, page low byte.
    function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                            input logic [7:0]  ptype,
                                            input logic [11:0] page);
        case (idx)
            2'd0:    return SYNC_BYTE;
            2'd1:    return ptype;
            2'd2:    return {4'h0, page[11:8]};
            default: return page[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// -----------------------------------------------------------------------------
// uart_tx_8n1
// Byte-level UART transmitter, 8 data bits, no parity, 1 stop bit.
//
// Ports:
//   MCLK      in   clock
//   nRESET    in   asynchronous active-low reset
//   tx_valid  in   byte strobe, only honoured while tx_ready=1
//   tx_data   in   byte to send (LSB first on the line)
//   tx_ready  out  high when a new byte can be accepted
//   TX        out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic       MCLK,
    input  logic       nRESET,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       TX
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             r_active;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [3:0]       r_bit_pos;   // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]       r_data;      // remaining data bits with the stop bit on top
    logic             r_tx;
    logic             w_bit_end;
    logic             w_stop_end;

    assign w_bit_end  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_stop_end = r_active && (r_bit_pos == 4'd9) && w_bit_end;

    // Ready during the final stop-bit cycle so the next start bit follows
    // immediately: consecutive bytes leave no idle gap on the line.
    assign tx_ready = !r_active || w_stop_end;
    assign TX       = r_tx;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_active  <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_pos <= 4'd0;
            r_data    <= 9'h1FF;
            r_tx      <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            r_active  <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_pos <= 4'd0;
            r_data    <= {1'b1, tx_data};
            r_tx      <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                if (r_bit_pos == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_pos <= r_bit_pos + 4'd1;
                    r_tx      <= r_data[0];
                    r_data    <= {1'b1, r_data[8:1]};
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bubble_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// bubble_fifo_uart_tx
// Captures the bit-serial page image into an 8192x1 buffer and, on a boot or
// user send request, streams it as a framed byte packet over UART 8N1:
//   A5, TYPE, {4'h0,PAGE[11:8]}, PAGE[7:0], LEN payload bytes, CHK
// Payload byte k is bits 8k..8k+7 with bit 8k as MSB; CHK is the modulo-256
// sum of the payload bytes.
//
// Ports:
//   MCLK             in   clock
//   nRESET           in   asynchronous active-low reset
//   nFIFOBUFWRCLKEN  in   low = write FIFOBUFWRDATA at FIFOBUFWRADDR
//   FIFOBUFWRADDR    in   buffer bit address
//   FIFOBUFWRDATA    in   buffer bit data
//   nFIFOSENDBOOT    in   falling edge requests a boot packet
//   nFIFOSENDUSER    in   falling edge requests a user packet
//   FIFOCURRPAGE     in   page number, sampled when a request is accepted
//   UART_TX          out  serial line, idle high
//   nBUSY            out  low while a packet is in progress
//   SENDERR          out  one-cycle pulse when a request is dropped
// -----------------------------------------------------------------------------
module bubble_fifo_uart_tx
    import bubble_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 48,
    parameter int BOOT_LEN_BYTES = 1024,
    parameter int USER_LEN_BYTES = 512
) (
    input  logic              MCLK,
    input  logic              nRESET,
    input  logic              nFIFOBUFWRCLKEN,
    input  logic [BUF_AW-1:0] FIFOBUFWRADDR,
    input  logic              FIFOBUFWRDATA,
    input  logic              nFIFOSENDBOOT,
    input  logic              nFIFOSENDUSER,
    input  logic [11:0]       FIFOCURRPAGE,
    output logic              UART_TX,
    output logic              nBUSY,
    output logic              SENDERR
);

    localparam logic [10:0] BOOT_LEN = 11'(BOOT_LEN_BYTES);
    localparam logic [10:0] USER_LEN = 11'(USER_LEN_BYTES);

    logic              r_mem [BUF_DEPTH];
    logic              r_rd_data;

    state_t            r_state;
    logic              r_boot_prev;
    logic              r_user_prev;
    logic [7:0]        r_type;
    logic [11:0]       r_page;
    logic [10:0]       r_len;
    logic [10:0]       r_byte_cnt;
    logic [1:0]        r_hdr_idx;
    logic [3:0]        r_fcnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_chk;
    logic              r_nbusy;
    logic              r_senderr;

    logic              w_boot_req;
    logic              w_user_req;
    logic              w_idle;
    logic              w_accept_boot;
    logic              w_accept_user;
    logic              w_drop;
    logic              w_last_byte;
    logic [BUF_AW-1:0] w_rd_addr;
    logic              w_tx_valid;
    logic [7:0]        w_tx_data;
    logic              w_tx_ready;

    assign w_boot_req    = r_boot_prev && !nFIFOSENDBOOT;
    assign w_user_req    = r_user_prev && !nFIFOSENDUSER;
    assign w_idle        = (r_state == IDLE);
    assign w_accept_boot = w_idle && w_boot_req;
    assign w_accept_user = w_idle && w_user_req && !w_boot_req;
    // Dropped: anything while busy, or the user half of a simultaneous pair.
    assign w_drop        = (!w_idle && (w_boot_req || w_user_req)) ||
                           (w_idle && w_boot_req && w_user_req);
    assign w_last_byte   = (r_byte_cnt == r_len - 11'd1);
    // r_fcnt wraps to 0 on its 9th (drain) cycle, which just re-reads a harmless bit.
    assign w_rd_addr     = {r_byte_cnt[9:0], r_fcnt[2:0]};

    // NOTE: the buffer and its read register carry no reset; contents survive
    // nRESET and the array maps onto block RAM.
    always_ff @(posedge MCLK) begin
        if (!nFIFOBUFWRCLKEN) begin
            r_mem[FIFOBUFWRADDR] <= FIFOBUFWRDATA;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and no latch is inferred.
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            HDR: begin
                w_tx_valid = w_tx_ready;
                w_tx_data  = hdr_byte(r_hdr_idx, r_type, r_page);
            end
            SEND: begin
                w_tx_valid = w_tx_ready;
                w_tx_data  = r_shift;
            end
            CHK: begin
                w_tx_valid = w_tx_ready;
                w_tx_data  = r_chk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= IDLE;
            r_boot_prev <= 1'b1;
            r_user_prev <= 1'b1;
            r_type      <= 8'h00;
            r_page      <= 12'h000;
            r_len       <= 11'd0;
            r_byte_cnt  <= 11'd0;
            r_hdr_idx   <= 2'd0;
            r_fcnt      <= 4'd0;
            r_shift     <= 8'h00;
            r_chk       <= 8'h00;
            r_nbusy     <= 1'b1;
            r_senderr   <= 1'b0;
        end else begin
            r_boot_prev <= nFIFOSENDBOOT;
            r_user_prev <= nFIFOSENDUSER;
            r_senderr   <= w_drop;

            case (r_state)
                IDLE: begin
                    if (w_accept_boot || w_accept_user) begin
                        r_type     <= w_accept_boot ? TYPE_BOOT : TYPE_USER;
                        r_len      <= w_accept_boot ? BOOT_LEN : USER_LEN;
                        r_page     <= FIFOCURRPAGE;
                        r_chk      <= 8'h00;
                        r_byte_cnt <= 11'd0;
                        r_hdr_idx  <= 2'd0;
                        r_nbusy    <= 1'b0;
                        r_state    <= HDR;
                    end
                end

                HDR: begin
                    if (w_tx_ready) begin
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        if (r_hdr_idx == 2'd3) begin
                            r_fcnt  <= 4'd0;
                            r_state <= FETCH;
                        end
                    end
                end

                // Cycle 0 issues the read of bit 0; cycles 1..8 shift in the
                // previous cycle's read, so the byte is complete after 9 cycles.
                FETCH: begin
                    if (r_fcnt != 4'd0) begin
                        r_shift <= {r_shift[6:0], r_rd_data};
                    end
                    if (r_fcnt == 4'd8) begin
                        r_state <= SEND;
                    end else begin
                        r_fcnt <= r_fcnt + 4'd1;
                    end
                end

                // The next fetch runs while this byte is on the line.
                SEND: begin
                    if (w_tx_ready) begin
                        r_chk <= r_chk + r_shift;
                        if (w_last_byte) begin
                            r_state <= CHK;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 11'd1;
                            r_fcnt     <= 4'd0;
                            r_state    <= FETCH;
                        end
                    end
                end

                CHK: begin
                    if (w_tx_ready) begin
                        r_state <= DONE;
                    end
                end

                // tx_ready returns in the final stop-bit cycle of CHK.
                DONE: begin
                    if (w_tx_ready) begin
                        r_nbusy <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .tx_valid (w_tx_valid),
        .tx_data  (w_tx_data),
        .tx_ready (w_tx_ready),
        .TX       (UART_TX)
    );

    assign nBUSY   = r_nbusy;
    assign SENDERR = r_senderr;

endmodule

// File: tb/tb_bubble_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bubble_fifo_uart_tx
// Drives buffer fills and send requests, decodes the UART line into bytes and
// compares each packet with one built from a bit-array model of the buffer.
// -----------------------------------------------------------------------------
module tb_bubble_fifo_uart_tx;

    localparam int CPB      = 4;
    localparam int BOOT_LEN = 48;
    localparam int USER_LEN = 32;
    localparam int LIMIT    = 10 * CPB * (4 + BOOT_LEN + 1) + 200;

    logic        MCLK            = 1'b0;
    logic        nRESET          = 1'b1;
    logic        nFIFOBUFWRCLKEN = 1'b1;
    logic [12:0] FIFOBUFWRADDR   = 13'd0;
    logic        FIFOBUFWRDATA   = 1'b0;
    logic        nFIFOSENDBOOT   = 1'b1;
    logic        nFIFOSENDUSER   = 1'b1;
    logic [11:0] FIFOCURRPAGE    = 12'h000;
    logic        UART_TX;
    logic        nBUSY;
    logic        SENDERR;

    int          total = 0;
    int          bad   = 0;
    bit          model [8192];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];
    int          senderr_cycles = 0;
    int          rst_epoch      = 0;
    int          framing_errs   = 0;

    bubble_fifo_uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .BOOT_LEN_BYTES (BOOT_LEN),
        .USER_LEN_BYTES (USER_LEN)
    ) dut (
        .MCLK            (MCLK),
        .nRESET          (nRESET),
        .nFIFOBUFWRCLKEN (nFIFOBUFWRCLKEN),
        .FIFOBUFWRADDR   (FIFOBUFWRADDR),
        .FIFOBUFWRDATA   (FIFOBUFWRDATA),
        .nFIFOSENDBOOT   (nFIFOSENDBOOT),
        .nFIFOSENDUSER   (nFIFOSENDUSER),
        .FIFOCURRPAGE    (FIFOCURRPAGE),
        .UART_TX         (UART_TX),
        .nBUSY           (nBUSY),
        .SENDERR         (SENDERR)
    );

    always #5 MCLK = ~MCLK;

    always @(negedge nRESET) rst_epoch++;
    always @(negedge MCLK) if (SENDERR === 1'b1) senderr_cycles++;

    // UART receiver: samples each bit mid-period; a frame cut by reset is discarded.
    initial begin : uart_mon
        int         ep;
        logic [7:0] b;
        logic       stop_b;
        forever begin
            @(negedge UART_TX);
            ep = rst_epoch;
            repeat (CPB / 2) @(posedge MCLK);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge MCLK);
                #1 b[i] = UART_TX;
            end
            repeat (CPB) @(posedge MCLK);
            #1 stop_b = UART_TX;
            if (ep == rst_epoch && nRESET === 1'b1) begin
                if (stop_b !== 1'b1) framing_errs++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
    endfunction

    // Expected packet straight from the framing rules and the bit model.
    task automatic build_expected(input bit is_boot, input logic [11:0] page);
        int len;
        int sum;
        int v;
        len = is_boot ? BOOT_LEN : USER_LEN;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(is_boot ? 8'h42 : 8'h55);
        exp_q.push_back({4'h0, page[11:8]});
        exp_q.push_back(page[7:0]);
        for (int k = 0; k < len; k++) begin
            v = 0;
            for (int i = 0; i < 8; i++) v = v * 2 + int'(model[8 * k + i]);
            exp_q.push_back(8'(v));
            sum += v;
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    // mode 0: bit = addr[0]^addr[3]; 1: all ones; 2: random
    task automatic fill(input int mode);
        logic [12:0] ad;
        bit          b;
        for (int a = 0; a < 8192; a++) begin
            ad = 13'(a);
            case (mode)
                0:       b = ad[0] ^ ad[3];
                1:       b = 1'b1;
                default: b = 1'($urandom);
            endcase
            @(negedge MCLK);
            nFIFOBUFWRCLKEN = 1'b0;
            FIFOBUFWRADDR   = ad;
            FIFOBUFWRDATA   = b;
            model[a]        = b;
        end
        @(negedge MCLK);
        nFIFOBUFWRCLKEN = 1'b1;
    endtask

    task automatic write_bit(input logic [12:0] ad, input bit b);
        @(negedge MCLK);
        nFIFOBUFWRCLKEN = 1'b0;
        FIFOBUFWRADDR   = ad;
        FIFOBUFWRDATA   = b;
        model[ad]       = b;
        @(negedge MCLK);
        nFIFOBUFWRCLKEN = 1'b1;
    endtask

    task automatic request(input bit boot, input bit user, input logic [11:0] page);
        rx_q.delete();
        framing_errs = 0;
        @(negedge MCLK);
        FIFOCURRPAGE  = page;
        nFIFOSENDBOOT = !boot;
        nFIFOSENDUSER = !user;
        @(negedge MCLK);
        nFIFOSENDBOOT = 1'b1;
        nFIFOSENDUSER = 1'b1;
    endtask

    // inj_kind 1: user request pulse; 2: write bit 0 = 1 (model preset by caller)
    task automatic run_packet(input string tag, input int n_payload,
                              input int inj_at, input int inj_kind);
        int w;
        int dur;
        int lo;
        int mism;
        int n;
        w = 0;
        while (nBUSY !== 1'b0 && w < 50) begin
            @(negedge MCLK);
            w++;
        end
        check({tag, "_busy_start"}, 32'(nBUSY), 32'd0);
        dur = 0;
        while (nBUSY === 1'b0 && dur < LIMIT) begin
            if (dur == inj_at) begin
                if (inj_kind == 1) nFIFOSENDUSER = 1'b0;
                if (inj_kind == 2) begin
                    nFIFOBUFWRCLKEN = 1'b0;
                    FIFOBUFWRADDR   = 13'd0;
                    FIFOBUFWRDATA   = 1'b1;
                end
            end else if (dur == inj_at + 1) begin
                nFIFOSENDUSER   = 1'b1;
                nFIFOBUFWRCLKEN = 1'b1;
            end
            dur++;
            @(negedge MCLK);
        end
        lo = (4 + n_payload + 1) * 10 * CPB;
        total++;
        assert (dur >= lo && dur <= lo + 10) else begin
            bad++;
            $error("FAIL %s_busy_dur: observed=%0d expected=%0d..%0d", tag, dur, lo, lo + 10);
        end
        repeat (5) @(negedge MCLK);
        n = exp_q.size();
        check({tag, "_nbytes"}, rx_q.size(), n);
        for (int i = 0; i < 4; i++) check($sformatf("%s_hdr%0d", tag, i), rx_at(i), {24'h0, exp_q[i]});
        mism = 0;
        for (int i = 4; i < n - 1; i++) if (rx_at(i) !== {24'h0, exp_q[i]}) mism++;
        check({tag, "_payload_mismatches"}, mism, 0);
        check({tag, "_chk"}, rx_at(n - 1), {24'h0, exp_q[n - 1]});
        check({tag, "_framing_errs"}, framing_errs, 0);
    endtask

    initial begin : stim
        logic [11:0] page;
        int          w;
        int          held;

        // Reset state
        #2 nRESET = 1'b0;
        #1;
        check("rst_uart_tx", 32'(UART_TX), 32'd1);
        check("rst_nbusy",   32'(nBUSY),   32'd1);
        check("rst_senderr", 32'(SENDERR), 32'd0);
        repeat (3) @(negedge MCLK);
        nRESET = 1'b1;
        repeat (3) @(negedge MCLK);
        check("idle_uart_tx", 32'(UART_TX), 32'd1);

        // 1: alternating pattern, user request, page 2B7
        fill(0);
        build_expected(1'b0, 12'h2B7);
        senderr_cycles = 0;
        request(1'b0, 1'b1, 12'h2B7);
        run_packet("user_pattern", USER_LEN, -1, 0);
        check("user_pattern_senderr", senderr_cycles, 0);

        // 2: all ones, boot request, page 0 -> CHK = (LEN*255) mod 256
        fill(1);
        build_expected(1'b1, 12'h000);
        request(1'b1, 1'b0, 12'h000);
        run_packet("boot_ones", BOOT_LEN, -1, 0);

        // 3: random data, simultaneous boot and user -> boot only, one SENDERR cycle
        fill(2);
        page = 12'($urandom);
        build_expected(1'b1, page);
        senderr_cycles = 0;
        request(1'b1, 1'b1, page);
        run_packet("both_req", BOOT_LEN, -1, 0);
        check("both_req_senderr", senderr_cycles, 1);

        // 4: user request in the middle of a boot packet is dropped
        page = 12'($urandom);
        build_expected(1'b1, page);
        senderr_cycles = 0;
        request(1'b1, 1'b0, page);
        run_packet("busy_req", BOOT_LEN, 300, 1);
        check("busy_req_senderr", senderr_cycles, 1);

        // 5: reset during payload byte 10 (packet byte 14)
        page = 12'($urandom);
        request(1'b0, 1'b1, page);
        w = 0;
        while (rx_q.size() < 14 && w < LIMIT) begin
            @(negedge MCLK);
            w++;
        end
        check("rst_mid_progress", 32'(rx_q.size() >= 14), 32'd1);
        w = 0;
        while (UART_TX !== 1'b0 && w < 60) begin
            @(posedge MCLK);
            w++;
        end
        check("rst_mid_tx_low_before", 32'(UART_TX), 32'd0);
        #2 nRESET = 1'b0;
        #1;
        check("rst_mid_uart_tx", 32'(UART_TX), 32'd1);
        check("rst_mid_nbusy",   32'(nBUSY),   32'd1);
        held = rx_q.size();
        repeat (3) @(negedge MCLK);
        nRESET = 1'b1;
        repeat (80) @(negedge MCLK);
        check("rst_mid_idle_tx",    32'(UART_TX), 32'd1);
        check("rst_mid_idle_nbusy", 32'(nBUSY),   32'd1);
        check("rst_mid_no_more_bytes", rx_q.size(), held);
        page = 12'($urandom);
        build_expected(1'b0, page);
        request(1'b0, 1'b1, page);
        run_packet("after_rst", USER_LEN, -1, 0);

        // 6: bit 0 written 0 -> 1 during the header is seen by the first payload byte
        write_bit(13'd0, 1'b0);
        model[0] = 1'b1;
        page = 12'($urandom);
        build_expected(1'b0, page);
        request(1'b0, 1'b1, page);
        run_packet("wr_in_hdr", USER_LEN, 5, 2);
        check("wr_in_hdr_msb", 32'(rx_at(4) >> 7), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
